// File: rtl/decoder_gate_pkg.sv
// Shared definitions for the decoder-based gate arbiter: op codes, gate truth
// tables and FSM state encoding.
package decoder_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_BUF_A = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Entry [op] is the truth table of that gate, bit {a,b} holds the output.
    localparam logic [7:0][3:0] MASK_TABLE = {
        4'b1100,  // BUF_A
        4'b0011,  // NOT_A
        4'b1001,  // XNOR
        4'b0110,  // XOR
        4'b0001,  // NOR
        4'b0111,  // NAND
        4'b1110,  // OR
        4'b1000   // AND
    };

    function automatic logic gate_eval(input logic [3:0] minterm, input logic [2:0] sel);
        return |(minterm & MASK_TABLE[sel]);
    endfunction

endpackage

// File: rtl/decoder_gate_arbiter_dec2to4.sv
// 2-to-4 one-hot minterm decoder feeding the shared gate unit.
module dec2to4 (
    input  logic       a,
    input  logic       b,
    output logic [3:0] m
);

    // One-hot minterm select from {a,b}
    always_comb begin
        case ({a, b})
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0010;
            2'b10:   m = 4'b0100;
            2'b11:   m = 4'b1000;
            default: m = 4'b0000;
        endcase
    end

endmodule

// File: rtl/decoder_gate_arbiter.sv
// Round-robin arbiter sharing one decoder-based gate unit among N_REQ
// requesters; IDLE -> EVAL (grant pulse) -> RESP (held until acknowledged).
module decoder_gate_arbiter
    import decoder_gate_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   a,
    input  logic [N_REQ-1:0]   b,
    input  logic [3*N_REQ-1:0] op,
    input  logic               res_ack,
    output logic [N_REQ-1:0]   gnt,
    output logic               res,
    output logic               res_valid,
    output logic [ID_W-1:0]    res_id,
    output logic               busy
);

    state_e                    state_q, state_d;
    logic [ID_W-1:0]           ptr_q, ptr_d;
    logic [ID_W-1:0]           win_q, win_d;
    logic                      a_q, a_d;
    logic                      b_q, b_d;
    logic [2:0]                op_q, op_d;
    logic [N_REQ-1:0]          gnt_q, gnt_d;
    logic                      res_q, res_d;
    logic                      res_valid_q, res_valid_d;
    logic [ID_W-1:0]           res_id_q, res_id_d;
    logic                      busy_q, busy_d;

    logic                      found_s;
    logic [ID_W-1:0]           win_s;
    logic [ID_W-1:0]           idx_s;
    logic [3:0]                minterm_s;
    logic [N_REQ-1:0][2:0]     op_pk_s;

    assign op_pk_s = op;

    dec2to4 u_dec (
        .a (a_q),
        .b (b_q),
        .m (minterm_s)
    );

    // Round-robin search: first requesting index at or after ptr
    always_comb begin
        found_s = 1'b0;
        win_s   = ptr_q;
        idx_s   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            op_q        <= 3'd0;
            gnt_q       <= '0;
            res_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            gnt_q       <= gnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            busy_q      <= busy_d;
        end
    end

    // Next state; the winner's operands are captured once, in IDLE
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_EVAL;
                    win_d   = win_s;
                    a_d     = a[win_s];
                    b_d     = b[win_s];
                    op_d    = op_pk_s[win_s];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: state_d = ST_RESP;
            ST_RESP: begin
                if (res_ack) begin
                    state_d = ST_IDLE;
                    ptr_d   = ID_W'((int'(win_q) + 1) % N_REQ);
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values, registered so they line up with the state they describe
    always_comb begin
        gnt_d       = '0;
        res_d       = res_q;
        res_id_d    = res_id_q;
        res_valid_d = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_d = N_REQ'(1) << win_s;
                end else begin
                    gnt_d = '0;
                end
            end
            ST_EVAL: begin
                res_d       = gate_eval(minterm_s, op_q);
                res_id_d    = win_q;
                res_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (res_ack) begin
                    res_valid_d = 1'b0;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: res_valid_d = 1'b0;
        endcase
    end

    assign gnt       = gnt_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_decoder_gate_arbiter.sv
// Directed bench for decoder_gate_arbiter with a transaction-level reference
// model checked every cycle, plus literal expectations for key scenarios.
module tb_decoder_gate_arbiter;
    import decoder_gate_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [3:0]  a = 4'd0;
    logic [3:0]  b = 4'd0;
    logic [11:0] op = 12'd0;
    logic        res_ack = 1'b0;
    logic [3:0]  gnt;
    logic        res;
    logic        res_valid;
    logic [1:0]  res_id;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // reference model: age = cycles since a request was accepted (0 = none)
    int m_age = 0, m_ptr = 0, m_owner = 0, m_res = 0, m_id = 0, m_pend = 0;

    decoder_gate_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .op(op),
        .res_ack(res_ack), .gnt(gnt), .res(res), .res_valid(res_valid),
        .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int ref_gate(input int av, input int bv, input int sel);
        case (sel)
            0:       return av & bv;
            1:       return av | bv;
            2:       return 1 - (av & bv);
            3:       return 1 - (av | bv);
            4:       return av ^ bv;
            5:       return 1 - (av ^ bv);
            6:       return 1 - av;
            default: return av;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_age = 0; m_ptr = 0; m_owner = 0; m_res = 0; m_id = 0; m_pend = 0;
        end else if (m_age == 0) begin
            int w;
            w = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && ((int'(req) >> ((m_ptr + k) % 4)) & 1) == 1) w = (m_ptr + k) % 4;
            end
            if (w >= 0) begin
                m_owner = w;
                m_pend  = ref_gate((int'(a) >> w) & 1, (int'(b) >> w) & 1,
                                   (int'(op) >> (3 * w)) & 7);
                m_age   = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
            m_res = m_pend;
            m_id  = m_owner;
        end else if (res_ack) begin
            m_age = 0;
            m_ptr = (m_owner + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_gnt",   int'(gnt),       (m_age == 1) ? (1 << m_owner) : 0);
            check("mdl_valid", int'(res_valid), (m_age == 2) ? 1 : 0);
            check("mdl_busy",  int'(busy),      (m_age != 0) ? 1 : 0);
            if (m_age == 2) begin
                check("mdl_res", int'(res),    m_res);
                check("mdl_id",  int'(res_id), m_id);
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("idle_timeout", 1, 0);
    endtask

    // One transaction on requester idx; returns result seen on the first RESP cycle
    task automatic do_txn(input int idx, input logic av, input logic bv, input logic [2:0] opv,
                          output int r, output int id);
        wait_idle();
        req[idx] = 1'b1;
        a[idx]   = av;
        b[idx]   = bv;
        op[3*idx +: 3] = opv;
        @(negedge clk);
        check("txn_gnt", int'(gnt), 1 << idx);
        req = 4'd0;
        a   = ~a;
        b   = ~b;
        op  = ~op;
        @(negedge clk);
        check("txn_valid", int'(res_valid), 1);
        r  = int'(res);
        id = int'(res_id);
    endtask

    initial begin
        int r, id, exp;
        int gcyc[$];
        int gwin[$];
        int ids[$];
        logic [3:0] masks [8];
        masks = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b0011, 4'b1100};

        repeat (2) @(negedge clk);
        check("rst_gnt",   int'(gnt), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_res",   int'(res), 0);
        check("rst_id",    int'(res_id), 0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // all requesting, ack held: order 0,1,2,3,0 one grant per 3 cycles
        @(negedge clk);
        req = 4'hF; res_ack = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (gnt != 4'd0) begin
                gcyc.push_back(c);
                gwin.push_back(int'(gnt));
            end
            if (res_valid) ids.push_back(int'(res_id));
        end
        req = 4'd0;
        check("rr_id_count", (ids.size() >= 5) ? 1 : 0, 1);
        check("rr_gnt_count", (gcyc.size() >= 5) ? 1 : 0, 1);
        for (int i = 0; i < 5 && i < ids.size(); i++) check("rr_id", ids[i], i % 4);
        for (int i = 0; i < 5 && i < gwin.size(); i++) check("rr_gnt", gwin[i], 1 << (i % 4));
        for (int i = 1; i < 5 && i < gcyc.size(); i++) check("rr_period", gcyc[i] - gcyc[i-1], 3);
        wait_idle();

        // single AND on requester 0
        do_txn(0, 1'b1, 1'b1, OP_AND, r, id);
        check("and_res", r, 1);
        check("and_id", id, 0);

        // all ops x all inputs on requester 2, immediate ack
        for (int o = 0; o < 8; o++) begin
            for (int ab = 0; ab < 4; ab++) begin
                do_txn(2, ab[1], ab[0], o[2:0], r, id);
                exp = int'(masks[o][ab[1:0]]);
                check("sweep_res", r, exp);
                check("sweep_id", id, 2);
            end
        end

        // stall in RESP for 5 cycles
        wait_idle();
        res_ack = 1'b0;
        do_txn(1, 1'b1, 1'b0, OP_XOR, r, id);
        check("stall_res0", r, 1);
        check("stall_id0", id, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_valid", int'(res_valid), 1);
            check("stall_res", int'(res), 1);
            check("stall_id", int'(res_id), 1);
            check("stall_gnt", int'(gnt), 0);
            check("stall_busy", int'(busy), 1);
        end
        res_ack = 1'b1;
        @(negedge clk);
        check("ack_busy", int'(busy), 0);
        check("ack_valid", int'(res_valid), 0);

        // reset during EVAL discards the transaction and restarts from ptr 0
        wait_idle();
        req = 4'b0100; a = 4'b0100; b = 4'b0100; op = 12'd0;
        @(negedge clk);
        check("pre_rst_gnt", int'(gnt), 4);
        #2 rst = 1'b1;
        #1;
        check("async_gnt", int'(gnt), 0);
        check("async_valid", int'(res_valid), 0);
        check("async_busy", int'(busy), 0);
        check("async_res", int'(res), 0);
        check("async_id", int'(res_id), 0);
        req = 4'd0;
        @(negedge clk);
        check("rst_hold_valid", int'(res_valid), 0);
        rst = 1'b0;
        req = 4'b0110; a = 4'b0010; b = 4'b0000; op = {3'd0, 3'd0, OP_OR, 3'd0};
        @(negedge clk);
        check("post_rst_gnt", int'(gnt), 2);
        req = 4'd0;
        @(negedge clk);
        check("post_rst_valid", int'(res_valid), 1);
        check("post_rst_id", int'(res_id), 1);
        check("post_rst_res", int'(res), 1);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
